// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared types, constants and byte/word helpers for the
//                iterative AES encryption core (state encoding, round
//                constants, GF(2^8) doubling, MixColumns on one column,
//                ShiftRows on a full state, RotWord, round-count derivation).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ROUND = 1'b1
   } state_t;

   // Indexed directly by the AES round/group number; entry 0 and 11..15 unused.
   localparam logic [7:0] RCON [0:15] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic int nr_of(input int key_bits);
      return (key_bits == 128) ? 10 : 14;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes are row 0 in the MSBs down to row 3 in the LSBs.
   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte n of the state sits at [127-8n -: 8]; byte 4c+r is row r, column c.
   // Row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box (8-bit table lookup).
//  Ports       : din  - input byte
//                dout - substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   // Entry 0 occupies the MSBs, so entry n sits at bit offset 8*(255-n).
   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign dout = TABLE[{~din, 3'b000} +: 8];

endmodule : aes_sbox
`default_nettype wire

// File: rtl/aes_enc_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_enc_iter
//  Description : Iterative AES-128/AES-256 encryption core, one round per
//                clock, round keys expanded on the fly from a key window.
//  Parameters  : KEY_BITS - 128 or 256
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                start           - request, taken only while ready=1
//                block, key      - plaintext and cipher key (sampled on accept)
//                ready           - idle, can accept start
//                result_valid    - one-cycle completion pulse
//                result          - ciphertext, held until next completion
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_iter
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [127:0]        block,
   input  logic [KEY_BITS-1:0] key,
   output logic                ready,
   output logic                result_valid,
   output logic [127:0]        result
);

   localparam int         NR   = nr_of(KEY_BITS);
   localparam logic [3:0] LAST = 4'(NR);

   if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_enc_iter: KEY_BITS must be 128 or 256");
   end

   state_t              state;
   logic [3:0]          round;
   logic [127:0]        state_reg;
   logic [KEY_BITS-1:0] win;

   // ---------------- data path ----------------
   logic [127:0] sub_bytes, shifted, mixed, rk, round_out;

   for (genvar i = 0; i < 16; i++) begin : g_data_sbox
      aes_sbox u_sbox (.din(state_reg[8*i +: 8]), .dout(sub_bytes[8*i +: 8]));
   end

   assign shifted = shift_rows(sub_bytes);

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mixed[127 - 32*c -: 32] = mix_column(shifted[127 - 32*c -: 32]);
   end

   // The final round skips MixColumns.
   assign round_out = ((round == LAST) ? shifted : mixed) ^ rk;

   // ---------------- key path ----------------
   // wb is always the most recent four key words; its last word feeds SubWord.
   logic [127:0]        wb, base, new4;
   logic [KEY_BITS-1:0] win_next;
   logic                rot;
   logic [3:0]          rcon_idx;
   logic [31:0]         sub_in, sub_word, t, n0, n1, n2, n3;

   assign wb     = win[127:0];
   assign sub_in = rot ? rot_word(wb[31:0]) : wb[31:0];

   for (genvar j = 0; j < 4; j++) begin : g_key_sbox
      aes_sbox u_sbox (.din(sub_in[8*j +: 8]), .dout(sub_word[8*j +: 8]));
   end

   assign t    = sub_word ^ {(rot ? RCON[rcon_idx] : 8'h00), 24'h000000};
   assign n0   = base[127:96] ^ t;
   assign n1   = base[95:64]  ^ n0;
   assign n2   = base[63:32]  ^ n1;
   assign n3   = base[31:0]   ^ n2;
   assign new4 = {n0, n1, n2, n3};

   if (KEY_BITS == 128) begin : g_ks128
      // Window holds rk(r-1); this round's key is one expansion step ahead.
      assign rot      = 1'b1;
      assign rcon_idx = round;
      assign base     = wb;
      assign rk       = new4;
      assign win_next = new4;
   end else begin : g_ks256
      // Window {wa, wb}: rk(r) = wb, new4 is key group r+1. Odd rounds
      // produce even groups, which take RotWord and Rcon[group/2].
      logic [3:0] grp;
      assign grp      = round + 4'd1;
      assign rot      = round[0];
      assign rcon_idx = {1'b0, grp[3:1]};
      assign base     = win[KEY_BITS-1 -: 128];
      assign rk       = wb;
      assign win_next = {wb, new4};
   end

   // ---------------- control ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         round        <= '0;
         state_reg    <= '0;
         win          <= '0;
         ready        <= 1'b1;
         result_valid <= 1'b0;
         result       <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state_reg <= block ^ key[KEY_BITS-1 -: 128];
                  win       <= key;
                  round     <= 4'd1;
                  ready     <= 1'b0;
                  state     <= ROUND;
               end
            end
            ROUND: begin
               if (round == LAST) begin
                  result       <= round_out;
                  result_valid <= 1'b1;
                  ready        <= 1'b1;
                  round        <= '0;
                  state        <= IDLE;
               end else begin
                  state_reg <= round_out;
                  win       <= win_next;
                  round     <= round + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule : aes_enc_iter
`default_nettype wire

// File: tb/tb_aes_enc_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_enc_iter
//  Description : Directed self-checking bench for aes_enc_iter, one AES-128
//                and one AES-256 instance, FIPS-197 known-answer vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_enc_iter;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] K3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s128 = 1'b0, s256 = 1'b0;
   logic [127:0] b128 = '0, b256 = '0;
   logic [127:0] k128 = '0;
   logic [255:0] k256 = '0;
   logic         rdy128, v128, rdy256, v256;
   logic [127:0] r128, r256;

   int n_cmp = 0;
   int n_bad = 0;
   int n;
   int pulses;

   always #5 clk = ~clk;

   aes_enc_iter #(.KEY_BITS(128)) dut128 (
      .clk(clk), .rst(rst), .start(s128), .block(b128), .key(k128),
      .ready(rdy128), .result_valid(v128), .result(r128)
   );

   aes_enc_iter #(.KEY_BITS(256)) dut256 (
      .clk(clk), .rst(rst), .start(s256), .block(b256), .key(k256),
      .ready(rdy256), .result_valid(v256), .result(r256)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // n counts cycles from the start cycle (1 = first cycle after acceptance).
   task automatic wait_v(input bit wide, inout int cnt);
      while (!(wide ? v256 : v128) && cnt < 60) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   // Issue one AES-128 request and leave the bench just after the accept edge.
   task automatic go128(input logic [127:0] p, input logic [127:0] k);
      b128 = p; k128 = k; s128 = 1'b1;
      @(posedge clk); #1;
      s128 = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_ready",  128'(rdy128), 128'd1);
      check_eq("reset_valid",  128'(v128),   128'd0);
      check_eq("reset_result", r128,         128'd0);
      check_eq("reset_ready256", 128'(rdy256), 128'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic AES-128 vector
      go128(P1, K1);
      check_eq("busy_ready", 128'(rdy128), 128'd0);
      n = 1; wait_v(1'b0, n);
      check_eq("lat128_a", 128'(n), 128'd11);
      check_eq("res128_a", r128, C1);
      check_eq("ready_with_valid", 128'(rdy128), 128'd1);
      @(posedge clk); #1;
      check_eq("pulse_single_a", 128'(v128), 128'd0);

      // Second vector, then result holds over idle cycles
      go128(P2, K2);
      n = 1; wait_v(1'b0, n);
      check_eq("lat128_b", 128'(n), 128'd11);
      check_eq("res128_b", r128, C2);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (v128) pulses++;
      end
      check_eq("hold_result", r128, C2);
      check_eq("hold_no_pulse", 128'(pulses), 128'd0);

      // AES-256
      b256 = P1; k256 = K3; s256 = 1'b1;
      @(posedge clk); #1;
      s256 = 1'b0;
      n = 1; wait_v(1'b1, n);
      check_eq("lat256", 128'(n), 128'd15);
      check_eq("res256", r256, C3);
      @(posedge clk); #1;
      check_eq("pulse_single_256", 128'(v256), 128'd0);

      // Back-to-back with start held high, alternating vectors
      b128 = P1; k128 = K1; s128 = 1'b1;
      @(posedge clk); #1;
      n = 1;
      for (int i = 0; i < 4; i++) begin
         wait_v(1'b0, n);
         check_eq("b2b_lat", 128'(n), 128'd11);
         check_eq("b2b_res", r128, (i % 2 == 0) ? C1 : C2);
         if (i % 2 == 0) begin b128 = P2; k128 = K2; end
         else            begin b128 = P1; k128 = K1; end
         if (i == 3) s128 = 1'b0;
         @(posedge clk); #1;
         check_eq("b2b_pulse_single", 128'(v128), 128'd0);
         n = 1;
      end

      // Start pulse and input changes mid-operation are ignored
      go128(P1, K1);
      n = 1;
      repeat (2) begin @(posedge clk); #1; n++; end
      b128 = P2; k128 = K2; s128 = 1'b1;
      @(posedge clk); #1; n++;
      s128 = 1'b0;
      wait_v(1'b0, n);
      check_eq("midop_lat", 128'(n), 128'd11);
      check_eq("midop_res", r128, C1);
      @(posedge clk); #1;

      // Reset during round 5
      go128(P2, K2);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("rst_mid_ready",  128'(rdy128), 128'd1);
      check_eq("rst_mid_valid",  128'(v128),   128'd0);
      check_eq("rst_mid_result", r128,         128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (v128) pulses++;
      end
      check_eq("rst_no_pulse", 128'(pulses), 128'd0);
      go128(P1, K1);
      n = 1; wait_v(1'b0, n);
      check_eq("post_rst_lat", 128'(n), 128'd11);
      check_eq("post_rst_res", r128, C1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_aes_enc_iter
`default_nettype wire
